// File: rtl/red_der_izq_if.sv
// red_der_izq_if
//  Request/response bundle for the serial LSB-first comparison network.
//  master (stimulus side): drives start, a_p, b_p, x_p; reads busy, done, Z.
//  slave  (red_der_izq):   reads the request fields; drives busy, done, Z.
//  N is the operand MSB index: operands are N+1 bits, x_p is N bits wide.
interface red_der_izq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N:0]   a_p;
  logic [N:0]   b_p;
  logic [N-1:0] x_p;
  logic         busy;
  logic         done;
  logic         Z;

  modport master (
    output start, a_p, b_p, x_p,
    input  busy, done, Z
  );

  modport slave (
    input  start, a_p, b_p, x_p,
    output busy, done, Z
  );
endinterface

// File: rtl/red_der_izq.sv
// red_der_izq
//  Serial right-to-left comparison of two (N+1)-bit words, one bit cell per
//  clock. A 2-bit relation (EQ/GT/LT) is carried from bit 0 up to bit N and
//  reduced to a single predicate bit Z according to the captured mode.
//  Ports:
//    clk        rising-edge clock
//    reset      asynchronous, active-high reset
//    bus.start  request a comparison; only honoured while idle
//    bus.a_p    operand A, captured when start is accepted
//    bus.b_p    operand B, captured when start is accepted
//    bus.x_p    [1:0] initial relation (11 loads as EQ), [3:2] output mode;
//               higher bits ignored. Requires N >= 4.
//    bus.busy   high while bit cells are being evaluated
//    bus.done   one-cycle pulse when Z is updated
//    bus.Z      registered result, held until the next done
module red_der_izq #(
  parameter int N = 4
) (
  input logic          clk,
  input logic          reset,
  red_der_izq_if.slave bus
);
  localparam int IW = $clog2(N + 1);

  typedef enum logic { IDLE, RUN } stateT;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_GT = 2'b01,
    REL_LT = 2'b10
  } relT;

  stateT         state,    stateNext;
  relT           rel,      relNext;
  logic [N:0]    aReg,     aNext;
  logic [N:0]    bReg,     bNext;
  logic [1:0]    modeReg,  modeNext;
  logic [IW-1:0] idx,      idxNext;
  logic          busyReg,  busyNext;
  logic          doneReg,  doneNext;
  logic          zReg,     zNext;

  // Reduce the final relation to the selected predicate.
  function automatic logic evalMode(input logic [1:0] mode, input relT r);
    case (mode)
      2'b00:   return r == REL_GT;
      2'b01:   return r == REL_LT;
      2'b10:   return r == REL_EQ;
      default: return r != REL_EQ;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    stateNext = state;
    relNext   = rel;
    aNext     = aReg;
    bNext     = bReg;
    modeNext  = modeReg;
    idxNext   = idx;
    busyNext  = busyReg;
    doneNext  = 1'b0;
    zNext     = zReg;

    case (state)
      IDLE: begin
        if (bus.start) begin
          aNext     = bus.a_p;
          bNext     = bus.b_p;
          modeNext  = bus.x_p[3:2];
          relNext   = (bus.x_p[1:0] == 2'b11) ? REL_EQ : relT'(bus.x_p[1:0]);
          idxNext   = '0;
          busyNext  = 1'b1;
          stateNext = RUN;
        end
      end

      RUN: begin
        // Later (more significant) cells overwrite the relation, so the
        // highest differing bit decides; equal bits pass the relation through.
        if (aReg[idx] && !bReg[idx]) begin
          relNext = REL_GT;
        end else if (!aReg[idx] && bReg[idx]) begin
          relNext = REL_LT;
        end
        idxNext = idx + 1'b1;

        if (idx == IW'(N)) begin
          // Z uses the relation including this last cell, not the stale one.
          zNext     = evalMode(modeReg, relNext);
          doneNext  = 1'b1;
          busyNext  = 1'b0;
          idxNext   = '0;
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rel     <= REL_EQ;
      aReg    <= '0;
      bReg    <= '0;
      modeReg <= '0;
      idx     <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      zReg    <= 1'b0;
    end else begin
      state   <= stateNext;
      rel     <= relNext;
      aReg    <= aNext;
      bReg    <= bNext;
      modeReg <= modeNext;
      idx     <= idxNext;
      busyReg <= busyNext;
      doneReg <= doneNext;
      zReg    <= zNext;
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.Z    = zReg;
endmodule

// File: tb/tb_red_der_izq.sv
// tb_red_der_izq
//  Directed bench for red_der_izq with N=4: latency, predicate modes,
//  initial-relation tie-break, MSB priority, busy-ignore, mid-run reset and
//  held-start back-to-back operation.
module tb_red_der_izq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  red_der_izq_if #(.N(N)) bus ();

  red_der_izq #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Issue one request and wait for done. lat counts edges after the
  // accepting edge; -1 means done never arrived within the budget.
  task automatic doRun(input logic [N:0] a, input logic [N:0] b,
                       input logic [N-1:0] x, output logic z, output int lat);
    @(negedge clk);
    bus.a_p   = a;
    bus.b_p   = b;
    bus.x_p   = x;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    z = bus.Z;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_p   = '0;
    bus.b_p   = '0;
    bus.x_p   = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Z} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/Z got %b expected 000", {bus.busy, bus.done, bus.Z});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_gt_basic();
    logic z;
    int   lat;
    doRun(5'd22, 5'd19, 4'b0000, z, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL gt_basic_latency: got %0d expected 5", lat);
    end
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL gt_basic_z: got %b expected 1", z);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.Z} !== 2'b01) begin
      errors++;
      $display("FAIL gt_basic_pulse_hold: done/Z got %b expected 01", {bus.done, bus.Z});
    end
  endtask

  task automatic test_tie_break();
    logic z;
    int   lat;
    doRun(5'd13, 5'd13, 4'b0001, z, lat);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL tie_init_gt: got %b expected 1", z);
    end
    doRun(5'd13, 5'd13, 4'b0000, z, lat);
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL tie_init_eq: got %b expected 0", z);
    end
    // Initial code 11 must load as EQ, so equal operands read as equal.
    doRun(5'd13, 5'd13, 4'b1011, z, lat);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL tie_init_11_as_eq: got %b expected 1", z);
    end
  endtask

  task automatic test_eq_ne();
    logic z;
    int   lat;
    doRun(5'd31, 5'd31, 4'b1000, z, lat);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL eq_equal: got %b expected 1", z);
    end
    doRun(5'd31, 5'd30, 4'b1000, z, lat);
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL eq_differ: got %b expected 0", z);
    end
    doRun(5'd31, 5'd30, 4'b1100, z, lat);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL ne_differ: got %b expected 1", z);
    end
  endtask

  task automatic test_msb_priority();
    logic z;
    int   lat;
    doRun(5'd16, 5'd15, 4'b0100, z, lat);
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL msb_lt_mode: got %b expected 0", z);
    end
    doRun(5'd16, 5'd15, 4'b0000, z, lat);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL msb_gt_mode: got %b expected 1", z);
    end
  endtask

  task automatic test_busy_ignore();
    int   doneCnt = 0;
    logic zSeen   = 1'bx;
    @(negedge clk);
    bus.a_p   = 5'd5;
    bus.b_p   = 5'd9;
    bus.x_p   = 4'b0100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b expected 1", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_p   = 5'd31;
    bus.b_p   = 5'd0;
    bus.x_p   = 4'b0000;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        doneCnt++;
        zSeen = bus.Z;
      end
    end
    checks++;
    if (doneCnt !== 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d expected 1", doneCnt);
    end
    checks++;
    if (zSeen !== 1'b1) begin
      errors++;
      $display("FAIL busy_captured_z: got %b expected 1", zSeen);
    end
  endtask

  task automatic test_reset_mid_run();
    int   doneCnt = 0;
    logic z;
    int   lat;
    @(negedge clk);
    bus.a_p   = 5'd22;
    bus.b_p   = 5'd19;
    bus.x_p   = 4'b0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Z} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset_outputs: busy/done/Z got %b expected 000", {bus.busy, bus.done, bus.Z});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCnt++;
    end
    checks++;
    if (doneCnt !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d pulses expected 0", doneCnt);
    end
    doRun(5'd22, 5'd19, 4'b0000, z, lat);
    checks++;
    if (lat !== 5 || z !== 1'b1) begin
      errors++;
      $display("FAIL midrun_recover: lat/Z got %0d/%b expected 5/1", lat, z);
    end
  endtask

  task automatic test_back_to_back();
    int   e1 = -1;
    int   e2 = -1;
    logic z1 = 1'bx;
    logic z2 = 1'bx;
    @(negedge clk);
    bus.a_p   = 5'd3;
    bus.b_p   = 5'd2;
    bus.x_p   = 4'b0000;
    bus.start = 1'b1;
    // Edge 0 accepts; start stays high throughout.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (e1 < 0) begin
          e1      = i;
          z1      = bus.Z;
          bus.a_p = 5'd2;
          bus.b_p = 5'd3;
        end else if (e2 < 0) begin
          e2 = i;
          z2 = bus.Z;
        end
      end
      if (e2 >= 0) break;
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (e1 !== 5 || e2 !== 11) begin
      errors++;
      $display("FAIL b2b_timing: done edges got %0d,%0d expected 5,11", e1, e2);
    end
    checks++;
    if ({z1, z2} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_results: Z pair got %b expected 10", {z1, z2});
    end
  endtask

  initial begin
    test_reset();
    test_gt_basic();
    test_tie_break();
    test_eq_ne();
    test_msb_priority();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
